tour_cmd_sched: RTL



---
 rtl/tour_pkg.sv | 32 +++
 rtl/tour_move_decode.sv | 57 +++++
 rtl/tour_cmd_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tour_pkg
// Brief    : Shared state encoding, opcodes, headings and response bytes for
//            the knight's-tour command scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package tour_pkg;

  // Scheduler states: UART passthrough plus two legs per move, each with a
  // wait phase for the command processor's completion pulse.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] POS_ACK = 8'h5A;

endpackage
`default_nettype wire

// File: rtl/tour_move_decode.sv
`default_nettype none
// ============================================================================
// Module   : tour_move_decode
// Brief    : Combinational split of a one-hot knight move into a vertical-leg
//            command and a horizontal-leg command.
// Revision : 1.0 - initial release
// ============================================================================
module tour_move_decode
  import tour_pkg::*;
#(
  parameter logic [3:0] OP_V = OP_MOVE,
  parameter logic [3:0] OP_H = OP_FANFARE
) (
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic signed [2:0] w_dx;
  logic signed [2:0] w_dy;
  logic        [7:0] w_hdg_v;
  logic        [7:0] w_hdg_h;
  logic        [3:0] w_sq_v;
  logic        [3:0] w_sq_h;

  // Move bit to signed displacement; anything not one-hot yields a null move.
  always_comb begin
    w_dx = 3'sd0;
    w_dy = 3'sd0;
    case (move)
      8'h01: begin w_dx =  3'sd1; w_dy =  3'sd2; end
      8'h02: begin w_dx = -3'sd1; w_dy =  3'sd2; end
      8'h04: begin w_dx = -3'sd2; w_dy =  3'sd1; end
      8'h08: begin w_dx = -3'sd2; w_dy = -3'sd1; end
      8'h10: begin w_dx = -3'sd1; w_dy = -3'sd2; end
      8'h20: begin w_dx =  3'sd1; w_dy = -3'sd2; end
      8'h40: begin w_dx =  3'sd2; w_dy = -3'sd1; end
      8'h80: begin w_dx =  3'sd2; w_dy =  3'sd1; end
      default: begin w_dx = 3'sd0; w_dy = 3'sd0; end
    endcase
  end

  // Heading and magnitude per leg; a zero displacement keeps heading north.
  always_comb begin
    w_hdg_v = (w_dy < 0) ? HDG_SOUTH : HDG_NORTH;
    w_sq_v  = (w_dy < 0) ? 4'(-w_dy) : 4'(w_dy);
    if (w_dx > 0)      w_hdg_h = HDG_EAST;
    else if (w_dx < 0) w_hdg_h = HDG_WEST;
    else               w_hdg_h = HDG_NORTH;
    w_sq_h  = (w_dx < 0) ? 4'(-w_dx) : 4'(w_dx);
  end

  assign vert_cmd = {OP_V, w_hdg_v, w_sq_v};
  assign horz_cmd = {OP_H, w_hdg_h, w_sq_h};

endmodule
`default_nettype wire

// File: rtl/tour_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tour_cmd_sched
// Brief    : Arbitrates the command processor between UART passthrough and
//            playback of the solved knight's tour, two legs per move.
// Revision : 1.0 - initial release
// ============================================================================
module tour_cmd_sched
  import tour_pkg::*;
#(
  parameter int         NUM_MOVES  = 24,
  parameter logic [3:0] OP_MOVE    = tour_pkg::OP_MOVE,
  parameter logic [3:0] OP_FANFARE = tour_pkg::OP_FANFARE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      r_state;
  logic [4:0]  r_mv_indx;
  logic [15:0] w_vert_cmd;
  logic [15:0] w_horz_cmd;
  logic        w_last;

  tour_move_decode #(
    .OP_V (OP_MOVE),
    .OP_H (OP_FANFARE)
  ) u_decode (
    .move     (move),
    .vert_cmd (w_vert_cmd),
    .horz_cmd (w_horz_cmd)
  );

  assign mv_indx = r_mv_indx;
  assign w_last  = (r_mv_indx == LAST_IDX);

  // Tour sequencer: clr_cmd_rdy takes priority, so a coincident send_resp in
  // VERT/HORZ is dropped rather than skipping the wait phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_tour) begin
            r_mv_indx <= 5'd0;
            r_state   <= VERT;
          end
        end
        VERT:   if (clr_cmd_rdy) r_state <= WAIT_V;
        WAIT_V: if (send_resp)   r_state <= HORZ;
        HORZ:   if (clr_cmd_rdy) r_state <= WAIT_H;
        WAIT_H: begin
          if (send_resp) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + 5'd1;
              r_state   <= VERT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output steering: cmd only depends on state and a stable move, so it
  // cannot glitch while cmd_rdy is high.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = ACK;
    case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = ACK;
      end
      VERT, WAIT_V: begin
        cmd              = w_vert_cmd;
        cmd_rdy          = (r_state == VERT);
        clr_cmd_rdy_UART = 1'b0;
        resp             = POS_ACK;
      end
      HORZ, WAIT_H: begin
        cmd              = w_horz_cmd;
        cmd_rdy          = (r_state == HORZ);
        clr_cmd_rdy_UART = 1'b0;
        resp             = (r_state == WAIT_H && w_last) ? ACK : POS_ACK;
      end
      default: begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = ACK;
      end
    endcase
  end

endmodule
`default_nettype wire
